// File: rtl/mul8u_accum_pkg.sv
// -----------------------------------------------------------------------------
// mul8u_accum_pkg
// Shared types and constants for the product accumulation stage.
//   accum_state_t : frame FSM encoding (idle / frame open / result held)
//   PROD_W        : width of the unsigned product from the 8x8 multiplier
// -----------------------------------------------------------------------------
package mul8u_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } accum_state_t;

    localparam int PROD_W = 16;

endpackage

// File: rtl/mul8u_sat_add.sv
// -----------------------------------------------------------------------------
// mul8u_sat_add
// Adds a zero-extended product to the running accumulator. The sum is formed
// one bit wider than the accumulator so that the carry out can be seen.
//   acc_i   : current accumulator value
//   prod_i  : unsigned product to add
//   sum_o   : saturated (SAT=1) or wrapped (SAT=0) result
//   carry_o : the exact sum did not fit in ACC_W bits
// -----------------------------------------------------------------------------
module mul8u_sat_add
    import mul8u_accum_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SAT   = 1
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] sum_w;

    assign sum_w   = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign carry_o = sum_w[ACC_W];

    // Saturation clamps to all ones; otherwise the carry is simply dropped.
    assign sum_o = (carry_o && (SAT != 0)) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];

endmodule

// File: rtl/mul8u_accum_stage.sv
// -----------------------------------------------------------------------------
// mul8u_accum_stage
// Accumulates a stream of 16-bit multiplier products into one dot-product sum
// per frame (frame closed by in_last) and hands it on with valid/ready.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : product beat handshake
//   in_prod, in_last     : product value, frame-closing marker
//   out_valid/out_ready  : frame result handshake
//   out_sum              : frame sum (saturated or wrapped, see SAT)
//   out_count            : beats in the frame, saturating
//   out_ovf              : the frame sum exceeded the accumulator range
// -----------------------------------------------------------------------------
module mul8u_accum_stage
    import mul8u_accum_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8,
    parameter int SAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    accum_state_t     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] osum_q, osum_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    mul8u_sat_add #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_add (
        .acc_i   (acc_q),
        .prod_i  (in_prod),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Both handshake outputs come straight from the state register, so
    // neither depends combinationally on any input.
    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        osum_d  = osum_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_carry;
                    if (in_last) begin
                        // Result registers capture the closing beat on the
                        // same edge, so the result is valid one cycle later.
                        state_d = ST_DONE;
                        osum_d  = add_sum;
                        ocnt_d  = cnt_inc;
                        oovf_d  = ovf_q | add_carry;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            osum_q  <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            osum_q  <= osum_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

    assign out_sum   = osum_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;

endmodule
